// File: rtl/data_memory_controller_pkg.sv
// Shared definitions for the data-memory controller.
// Holds the load/store funct3 encodings, the controller state type and the
// bit positions of the enable flags inside MEM_READ / MEM_WRITE.
package data_memory_controller_pkg;

   // load funct3 (MEM_READ[2:0])
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // store funct3[1:0] (MEM_WRITE[1:0])
   localparam logic [1:0] F3_SB  = 2'b00;
   localparam logic [1:0] F3_SH  = 2'b01;
   localparam logic [1:0] F3_SW  = 2'b10;

   // enable bit positions
   localparam int RD_EN_BIT = 3;
   localparam int WR_EN_BIT = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/data_memory_controller_if.sv
// Pipeline <-> data-memory request/response bundle.
//   MEM_READ  [3]=load enable, [2:0]=funct3
//   MEM_WRITE [2]=store enable, [1:0]=funct3[1:0]
//   ADDRESS   byte address, WRITEDATA store data
//   READDATA  formatted load result, BUSYWAIT stall, MEM_FAULT fault pulse
// master = pipeline side, slave = memory controller side.
interface data_memory_controller_if;
   logic [3:0]  MEM_READ;
   logic [2:0]  MEM_WRITE;
   logic [31:0] ADDRESS;
   logic [31:0] WRITEDATA;
   logic [31:0] READDATA;
   logic        BUSYWAIT;
   logic        MEM_FAULT;

   modport master (
      output MEM_READ, MEM_WRITE, ADDRESS, WRITEDATA,
      input  READDATA, BUSYWAIT, MEM_FAULT
   );

   modport slave (
      input  MEM_READ, MEM_WRITE, ADDRESS, WRITEDATA,
      output READDATA, BUSYWAIT, MEM_FAULT
   );
endinterface

// File: rtl/data_memory_controller_aligner.sv
// mem_load_aligner: combinational load formatter.
//   word       raw 32-bit array word
//   addr_lo    byte offset within the word
//   funct3     load funct3
//   data       selected lane, sign/zero extended (0 on any fault)
//   misaligned halfword on odd byte or word not on a word boundary
//   reserved   funct3 is not a defined load
module mem_load_aligner
   import data_memory_controller_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data,
   output logic        misaligned,
   output logic        reserved
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = word[{addr_lo, 3'b000} +: 8];
   assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

   always_comb begin
      data       = '0;
      misaligned = 1'b0;
      reserved   = 1'b0;
      case (funct3)
         F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU: data = {24'h0, byte_sel};
         F3_LH: begin
            misaligned = addr_lo[0];
            data       = {{16{half_sel[15]}}, half_sel};
         end
         F3_LHU: begin
            misaligned = addr_lo[0];
            data       = {16'h0, half_sel};
         end
         F3_LW: begin
            misaligned = (addr_lo != 2'b00);
            data       = word;
         end
         default: reserved = 1'b1;
      endcase
      if (misaligned || reserved) data = '0;
   end

endmodule

// File: rtl/data_memory_controller.sv
// Data-memory responder for the MEM stage.
// Latches a load/store request, holds the pipeline with BUSYWAIT for a fixed
// ACCESS_LATENCY, then performs the access and presents the result for one
// DONE cycle.
//   CLK, RESET  clock, asynchronous active-high reset
//   bus         slave side of data_memory_controller_if
module data_memory_controller
   import data_memory_controller_pkg::*;
#(
   parameter int ADDR_BITS      = 10,
   parameter int ACCESS_LATENCY = 4
) (
   input  logic                     CLK,
   input  logic                     RESET,
   data_memory_controller_if.slave  bus
);

   localparam int CW = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

   state_t              state, state_nx;
   logic [CW-1:0]       cnt;
   logic [ADDR_BITS+1:0] req_addr;
   logic [31:0]         req_data;
   logic                req_store;
   logic [2:0]          req_f3;
   logic [31:0]         rdata_q;
   logic                fault_q;
   logic                busy;

   logic [31:0]         mem [2**ADDR_BITS];

   logic                rd_req, wr_req, request;
   logic                addr_hi_unused;
   logic [ADDR_BITS-1:0] idx;
   logic [31:0]         word;
   logic [31:0]         ld_data;
   logic                ld_mis, ld_res;
   logic [3:0]          be;
   logic [31:0]         wbytes;
   logic                st_fault;
   logic                op_fault;
   logic                do_op;

   assign rd_req  = bus.MEM_READ[RD_EN_BIT];
   assign wr_req  = bus.MEM_WRITE[WR_EN_BIT];
   assign request = rd_req | wr_req;

   // Upper address bits alias silently onto the array.
   assign addr_hi_unused = ^bus.ADDRESS[31:ADDR_BITS+2];

   assign idx  = req_addr[ADDR_BITS+1:2];
   assign word = mem[idx];

   mem_load_aligner u_align (
      .word       (word),
      .addr_lo    (req_addr[1:0]),
      .funct3     (req_f3),
      .data       (ld_data),
      .misaligned (ld_mis),
      .reserved   (ld_res)
   );

   // Store lane enables and replicated write data.
   always_comb begin
      be       = 4'b0000;
      wbytes   = req_data;
      st_fault = 1'b0;
      case (req_f3[1:0])
         F3_SB: begin
            be     = 4'b0001 << req_addr[1:0];
            wbytes = {4{req_data[7:0]}};
         end
         F3_SH: begin
            st_fault = req_addr[0];
            be       = req_addr[1] ? 4'b1100 : 4'b0011;
            wbytes   = {2{req_data[15:0]}};
         end
         F3_SW: begin
            st_fault = (req_addr[1:0] != 2'b00);
            be       = 4'b1111;
         end
         default: st_fault = 1'b1;
      endcase
   end

   assign op_fault = req_store ? st_fault : (ld_mis | ld_res);
   assign do_op    = (state == ACCESS) && (cnt == '0);

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      case (state)
         IDLE: begin
            busy = request;
            if (request) state_nx = ACCESS;
         end
         ACCESS: begin
            busy = 1'b1;
            if (cnt == '0) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         cnt       <= '0;
         req_addr  <= '0;
         req_data  <= '0;
         req_store <= 1'b0;
         req_f3    <= '0;
         rdata_q   <= '0;
         fault_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         fault_q <= 1'b0;  // pulse lives only in DONE
         case (state)
            IDLE: if (request) begin
               req_addr  <= bus.ADDRESS[ADDR_BITS+1:0];
               req_data  <= bus.WRITEDATA;
               req_store <= wr_req;
               // store wins when both enables are set
               req_f3    <= wr_req ? {1'b0, bus.MEM_WRITE[1:0]} : bus.MEM_READ[2:0];
               cnt       <= CW'(ACCESS_LATENCY - 1);
            end
            ACCESS: begin
               if (cnt != '0) cnt <= cnt - CW'(1);
               else begin
                  fault_q <= op_fault;
                  if (op_fault)       rdata_q <= '0;
                  else if (!req_store) rdata_q <= ld_data;
               end
            end
            default: ;
         endcase
      end
   end

   // Array has no reset; RESET forces state to IDLE so no write can fire.
   always_ff @(posedge CLK) begin
      if (do_op && req_store && !st_fault && !RESET) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wbytes[8*i +: 8];
      end
   end

   assign bus.BUSYWAIT  = busy & ~RESET;
   assign bus.READDATA  = rdata_q;
   assign bus.MEM_FAULT = fault_q;

endmodule
